// File: rtl/tpu_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters; grant->SRAM 1 cycle, grant->rsp 2 cycles.
// Never back-pressures for pipeline reasons; rsp consumers must always accept. Optional stall counters under TPU_SRAM_ARB_PERF_EN.
module tpu_sram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int HOLD_MAX   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout,
  output logic                          busy,
  output logic [NUM_REQ*16-1:0]         perf_wait_cnt
);

  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LOCK_W = 4;

  typedef logic [IDW-1:0] id_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    id_t                   id;
  } cmd_t;

  id_t                   rr_ptr_q, rr_ptr_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                  iss_vld_q, iss_vld_d;
  cmd_t                  iss_cmd_q, iss_cmd_d;
  logic                  rsp_vld_q, rsp_vld_d;
  id_t                   rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

  logic gnt_vld;
  id_t  gnt_id;

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = id_t'(idx);
      end
    end
  end

  assign req_ready = gnt_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = '0;
    iss_vld_d  = gnt_vld;
    iss_cmd_d  = iss_cmd_q;
    iss_cmd_d.we = 1'b0;
    if (gnt_vld) begin
      // A lock keeps the pointer on the winner until HOLD_MAX grants, then forces rotation.
      if (req_lock[gnt_id] && (lock_cnt_q < LOCK_W'(HOLD_MAX - 1))) begin
        rr_ptr_d   = gnt_id;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        rr_ptr_d = (gnt_id == id_t'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      iss_cmd_d.we   = req_we[gnt_id];
      iss_cmd_d.addr = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      iss_cmd_d.din  = req_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      iss_cmd_d.id   = gnt_id;
    end
    rsp_vld_d    = iss_vld_q & ~iss_cmd_q.we;
    rsp_id_d     = iss_cmd_q.id;
    rdata_hold_d = rsp_vld_q ? sram_dout : rdata_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_cnt_q   <= '0;
      iss_vld_q    <= 1'b0;
      iss_cmd_q    <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_cnt_q   <= lock_cnt_d;
      iss_vld_q    <= iss_vld_d;
      iss_cmd_q    <= iss_cmd_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign sram_cs   = iss_vld_q;
  assign sram_we   = iss_cmd_q.we;
  assign sram_addr = iss_cmd_q.addr;
  assign sram_din  = iss_cmd_q.din;
  assign rsp_valid = rsp_vld_q ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << rsp_id_q) : '0;
  assign rsp_rdata = rsp_vld_q ? sram_dout : rdata_hold_q;
  assign busy      = iss_vld_q | rsp_vld_q;

`ifdef TPU_SRAM_ARB_PERF_EN
  logic [NUM_REQ*16-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !req_ready[i] && (perf_q[i*16 +: 16] != 16'hFFFF)) begin
        perf_d[i*16 +: 16] = perf_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_wait_cnt = perf_q;
`else
  assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_tpu_sram_arbiter.sv
// Randomized and directed bench for tpu_sram_arbiter against a cycle-level reference model and a behavioural SRAM.
module tb_tpu_sram_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int HM = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_we = '0, req_lock = '0;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [DW-1:0]     rsp_rdata, sram_din, sram_dout;
  logic              sram_cs, sram_we, busy;
  logic [AW-1:0]     sram_addr;
  logic [N*16-1:0]   perf_wait_cnt;

  tpu_sram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(1024), .ADDR_WIDTH(AW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy), .perf_wait_cnt(perf_wait_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM, 1-cycle read latency, preloaded with an address hash.
  logic [DW-1:0] mem [0:1023];
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < 1024; a++) mem[a] <= (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [0:1023];
  int            m_ptr, m_lock;
  bit            m_iss_vld, m_iss_we;
  int            m_iss_addr, m_iss_id;
  logic [DW-1:0] m_iss_din, m_iss_rd;
  bit            m_rsp_vld;
  int            m_rsp_id;
  logic [DW-1:0] m_rsp_data, m_last;
  int            m_perf [N];

  task automatic m_reset();
    m_ptr = 0; m_lock = 0; m_iss_vld = 0; m_iss_we = 0; m_iss_addr = 0; m_iss_id = 0;
    m_iss_din = '0; m_iss_rd = '0; m_rsp_vld = 0; m_rsp_id = 0; m_rsp_data = '0; m_last = '0;
    for (int i = 0; i < N; i++) m_perf[i] = 0;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input bit lk, input int addr, input logic [DW-1:0] d);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, '0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model to the next edge.
  task automatic cycle();
    int g;
    int a;
    logic [N-1:0] exp_rdy;
    logic [15:0] exp_perf;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("sram_cs", sram_cs, m_iss_vld);
    if (m_iss_vld) begin
      chk("sram_we", sram_we, m_iss_we);
      chk("sram_addr", sram_addr, m_iss_addr);
      if (m_iss_we) chk("sram_din", sram_din, m_iss_din);
    end
    chk("rsp_valid", rsp_valid, m_rsp_vld ? (N'(1) << m_rsp_id) : N'(0));
    if (m_rsp_vld) m_last = m_rsp_data;
    chk("rsp_rdata", rsp_rdata, m_last);
    chk("busy", busy, m_iss_vld | m_rsp_vld);
    for (int i = 0; i < N; i++) begin
`ifdef TPU_SRAM_ARB_PERF_EN
      exp_perf = 16'(m_perf[i]);
`else
      exp_perf = 16'd0;
`endif
      chk($sformatf("perf_wait_cnt[%0d]", i), perf_wait_cnt[i*16 +: 16], exp_perf);
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && i != g && m_perf[i] < 16'hFFFF) m_perf[i]++;
    m_rsp_vld  = m_iss_vld && !m_iss_we;
    m_rsp_id   = m_iss_id;
    m_rsp_data = m_iss_rd;
    m_iss_vld  = (g >= 0);
    m_iss_we   = 0;
    if (g >= 0) begin
      a = int'(req_addr[g*AW +: AW]);
      m_iss_we = req_we[g]; m_iss_addr = a; m_iss_id = g;
      m_iss_din = req_wdata[g*DW +: DW];
      if (req_we[g]) ref_mem[a] = m_iss_din;
      else           m_iss_rd = ref_mem[a];
      if (req_lock[g] && m_lock < HM - 1) begin
        m_ptr = g; m_lock++;
      end else begin
        m_ptr = (g + 1) % N; m_lock = 0;
      end
    end else begin
      m_lock = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    m_reset();
    repeat (3) @(posedge clk);
    init_done = 1'b1;
    @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst sram_cs", sram_cs, 0);
    chk("rst sram_we", sram_we, 0);
    chk("rst sram_addr", sram_addr, 0);
    chk("rst sram_din", sram_din, 0);
    chk("rst busy", busy, 0);
    chk("rst perf", perf_wait_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    repeat (10) cycle();

    // Write then read-after-write by requester 2
    set_req(2, 1, 1, 0, 'h10, 32'hDEADBEEF);
    cycle();
    set_req(2, 1, 0, 0, 'h10, '0);
    cycle();
    clr_all();
    repeat (3) cycle();

    // All four reading continuously
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 'h40 + i, '0);
    repeat (9) cycle();
    clr_all();
    repeat (3) cycle();

    // Requester 1 locking against requester 3
    set_req(1, 1, 0, 1, 'h21, '0);
    set_req(3, 1, 0, 0, 'h23, '0);
    repeat (6) cycle();
    clr_all();
    repeat (3) cycle();

    // Requester 0 locking while requester 1 waits
    set_req(0, 1, 1, 1, 'h30, 32'h0BAD_F00D);
    set_req(1, 1, 0, 0, 'h30, '0);
    repeat (5) cycle();
    clr_all();
    repeat (3) cycle();

    // Random traffic over a small address window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                $urandom_range(0, 15), $urandom);
      cycle();
    end
    clr_all();
    repeat (3) cycle();

    // Reset right after a read handshake drops the in-flight read
    set_req(0, 1, 0, 0, 'h5, '0);
    cycle();
    clr_all();
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    chk("midrst sram_cs", sram_cs, 0);
    chk("midrst busy", busy, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst rsp_valid2", rsp_valid, 0);
    chk("midrst rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
